// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
package npc_ctrl_pkg;

    typedef enum logic [3:0] {
        RESET,
        FETCH,
        IWAIT,
        DECODE,
        EXEC,
        MREQ,
        MWAIT,
        WB,
        HALT
    } state_e;

    localparam int REGEN_BIT = 13;
    localparam int PCJEN_BIT = 12;
    localparam int PCREN_BIT = 11;
    localparam int MWEN_HI   = 10;
    localparam int MWEN_LO   = 9;
    localparam int MREN_HI   = 8;
    localparam int MREN_LO   = 7;

    localparam logic [1:0] HALT_EBREAK  = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL = 2'd1;
    localparam logic [1:0] HALT_TIMEOUT = 2'd2;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/npc_ctrl_watchdog.sv
// Wait-state watchdog: counts consecutive stalled cycles and flags the last allowed one.
module npc_ctrl_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q;

    // expired marks the TIMEOUT-th stalled cycle; the FSM still lets a same-cycle response win
    assign expired = tick && (cnt_q == W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (tick && !expired) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/npc_multicycle_ctrl.sv
// Multi-cycle sequencer: fetch, decode hand-off, EXEC/MEM/WB stepping and halt handling.
module npc_multicycle_ctrl
    import npc_ctrl_pkg::*;
#(
    parameter int MICRO_LEN = 14,
    parameter int INST_W    = 32,
    parameter int TIMEOUT   = 1023,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ifu_req_valid,
    input  logic                 ifu_req_ready,
    input  logic                 ifu_resp_valid,
    input  logic [INST_W-1:0]    ifu_resp_inst,
    output logic [INST_W-1:0]    inst_q,
    input  logic [MICRO_LEN-1:0] micro_cmd,
    input  logic                 micro_hit,
    output logic [MICRO_LEN-1:0] micro_q,
    output logic                 lsu_req_valid,
    input  logic                 lsu_req_ready,
    output logic                 lsu_req_we,
    output logic [1:0]           lsu_req_size,
    input  logic                 lsu_resp_valid,
    output logic                 rf_wen,
    output logic                 pc_wen,
    output logic                 halted,
    output logic [1:0]           halt_code,
    output logic [CNT_W-1:0]     instret
);
    state_e           state_q;
    logic             ifu_valid_q;
    logic             lsu_valid_q;
    logic             rf_wen_q;
    logic             pc_wen_q;
    logic             halted_q;
    logic [1:0]       halt_code_q;
    logic [CNT_W-1:0] instret_q;

    logic             waiting;
    logic             got_event;
    logic             wd_expired;
    logic             mem_op;

    assign ifu_req_valid = ifu_valid_q;
    assign lsu_req_valid = lsu_valid_q;
    assign rf_wen        = rf_wen_q;
    assign pc_wen        = pc_wen_q;
    assign halted        = halted_q;
    assign halt_code     = halt_code_q;
    assign instret       = instret_q;

    // a store encoding takes precedence when both MWEN and MREN are set
    assign lsu_req_we   = |micro_q[MWEN_HI:MWEN_LO];
    assign lsu_req_size = lsu_req_we ? micro_q[MWEN_HI:MWEN_LO] : micro_q[MREN_HI:MREN_LO];
    assign mem_op       = lsu_req_we || (|micro_q[MREN_HI:MREN_LO]);

    always_comb begin
        waiting   = 1'b0;
        got_event = 1'b0;
        case (state_q)
            FETCH:   begin waiting = 1'b1; got_event = ifu_req_ready;  end
            IWAIT:   begin waiting = 1'b1; got_event = ifu_resp_valid; end
            MREQ:    begin waiting = 1'b1; got_event = lsu_req_ready;  end
            MWAIT:   begin waiting = 1'b1; got_event = lsu_resp_valid; end
            default: ;
        endcase
    end

    npc_ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!(waiting && !got_event)),
        .tick    (waiting && !got_event),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET;
            ifu_valid_q <= 1'b0;
            lsu_valid_q <= 1'b0;
            rf_wen_q    <= 1'b0;
            pc_wen_q    <= 1'b0;
            halted_q    <= 1'b0;
            halt_code_q <= HALT_EBREAK;
            instret_q   <= '0;
            inst_q      <= '0;
            micro_q     <= '0;
        end else begin
            ifu_valid_q <= 1'b0;
            lsu_valid_q <= 1'b0;
            rf_wen_q    <= 1'b0;
            pc_wen_q    <= 1'b0;
            case (state_q)
                RESET: begin
                    state_q     <= FETCH;
                    ifu_valid_q <= 1'b1;
                end
                FETCH: begin
                    if (ifu_req_ready) begin
                        state_q <= IWAIT;
                    end else if (wd_expired) begin
                        state_q     <= HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HALT_TIMEOUT;
                    end else begin
                        ifu_valid_q <= 1'b1;
                    end
                end
                IWAIT: begin
                    if (ifu_resp_valid) begin
                        inst_q  <= ifu_resp_inst;
                        state_q <= DECODE;
                    end else if (wd_expired) begin
                        state_q     <= HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HALT_TIMEOUT;
                    end
                end
                DECODE: begin
                    micro_q <= micro_cmd;
                    if (inst_q == EBREAK_INST) begin
                        state_q     <= HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HALT_EBREAK;
                    end else if (!micro_hit) begin
                        state_q     <= HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HALT_ILLEGAL;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (mem_op) begin
                        state_q     <= MREQ;
                        lsu_valid_q <= 1'b1;
                    end else begin
                        state_q   <= WB;
                        rf_wen_q  <= micro_q[REGEN_BIT];
                        pc_wen_q  <= 1'b1;
                        instret_q <= instret_q + CNT_W'(1);
                    end
                end
                MREQ: begin
                    if (lsu_req_ready) begin
                        state_q <= MWAIT;
                    end else if (wd_expired) begin
                        state_q     <= HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HALT_TIMEOUT;
                    end else begin
                        lsu_valid_q <= 1'b1;
                    end
                end
                MWAIT: begin
                    if (lsu_resp_valid) begin
                        state_q   <= WB;
                        rf_wen_q  <= micro_q[REGEN_BIT];
                        pc_wen_q  <= 1'b1;
                        instret_q <= instret_q + CNT_W'(1);
                    end else if (wd_expired) begin
                        state_q     <= HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HALT_TIMEOUT;
                    end
                end
                WB: begin
                    state_q     <= FETCH;
                    ifu_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_npc_multicycle_ctrl.sv
// Self-checking bench: per-instruction phase timeline model driven with randomized port delays.
module tb_npc_multicycle_ctrl;
    localparam int TO = 8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam int PH_F = 0, PH_I = 1, PH_O = 2, PH_MQ = 3, PH_MW = 4;
    localparam int B_IFU = 87, B_LSU = 86, B_PC = 81, B_HALT = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_resp_inst, inst_q;
    logic [13:0] micro_cmd, micro_q;
    logic        micro_hit;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_resp_valid;
    logic [1:0]  lsu_req_size;
    logic        rf_wen, pc_wen, halted;
    logic [1:0]  halt_code;
    logic [31:0] instret;

    always #5 clk = ~clk;

    npc_multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst),
        .inst_q(inst_q), .micro_cmd(micro_cmd), .micro_hit(micro_hit), .micro_q(micro_q),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_we(lsu_req_we), .lsu_req_size(lsu_req_size), .lsu_resp_valid(lsu_resp_valid),
        .rf_wen(rf_wen), .pc_wen(pc_wen), .halted(halted), .halt_code(halt_code),
        .instret(instret)
    );

    typedef struct {
        logic        f_rdy, f_rsp, l_rdy, l_rsp;
        logic [31:0] rinst;
        logic [13:0] mc;
        logic        hit;
        logic [87:0] exp;
    } cyc_t;

    cyc_t        tr[$];
    logic [87:0] obs[$];
    int          checks = 0;
    int          failures = 0;
    int          mark;

    logic        m_halted, m_we;
    logic [1:0]  m_code, m_sz;
    logic [31:0] m_ret, m_inst;
    logic [13:0] m_micro;

    // One expected cycle; inputs not owned by the current phase carry random noise.
    task automatic push(input int ph, input logic ev, input logic rf, input logic pc,
                        input logic [31:0] inst, input logic [13:0] mc, input logic hit);
        cyc_t c;
        logic [3:0] nz;
        nz = 4'($urandom);
        c.f_rdy = (ph == PH_F)  ? ev : nz[0];
        c.f_rsp = (ph == PH_I)  ? ev : nz[1];
        c.l_rdy = (ph == PH_MQ) ? ev : nz[2];
        c.l_rsp = (ph == PH_MW) ? ev : nz[3];
        c.rinst = (ph == PH_I && ev) ? inst : $urandom;
        c.mc    = mc;
        c.hit   = hit;
        c.exp   = {ph == PH_F, ph == PH_MQ, (ph == PH_MQ) ? m_we : 1'b0,
                   (ph == PH_MQ) ? m_sz : 2'b00, rf, pc, m_halted,
                   m_halted ? m_code : 2'b00, m_ret, m_inst, m_micro};
        tr.push_back(c);
    endtask

    task automatic wait_phase(input int ph, input int d, input logic [31:0] inst,
                              input logic [13:0] mc, input logic hit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < TO; i++) begin
            push(ph, i == d, 1'b0, 1'b0, inst, mc, hit);
            if (i == d) begin
                ok = 1'b1;
                return;
            end
        end
        m_halted = 1'b1;
        m_code   = 2'd2;
    endtask

    task automatic add_inst(input logic [31:0] inst, input logic [13:0] mc, input logic hit,
                            input int d_fr, input int d_fs, input int d_lr, input int d_ls);
        logic ok;
        logic mem;
        if (m_halted) return;
        m_we = (mc[10:9] != 2'b00);
        m_sz = m_we ? mc[10:9] : mc[8:7];
        mem  = m_we || (mc[8:7] != 2'b00);
        wait_phase(PH_F, d_fr, inst, mc, hit, ok);
        if (!ok) return;
        wait_phase(PH_I, d_fs, inst, mc, hit, ok);
        if (!ok) return;
        m_inst = inst;
        push(PH_O, 1'b0, 1'b0, 1'b0, inst, mc, hit);
        m_micro = mc;
        if (inst == EBREAK) begin
            m_halted = 1'b1; m_code = 2'd0;
            return;
        end
        if (!hit) begin
            m_halted = 1'b1; m_code = 2'd1;
            return;
        end
        push(PH_O, 1'b0, 1'b0, 1'b0, inst, mc, hit);
        if (mem) begin
            wait_phase(PH_MQ, d_lr, inst, mc, hit, ok);
            if (!ok) return;
            mark = tr.size();
            wait_phase(PH_MW, d_ls, inst, mc, hit, ok);
            if (!ok) return;
        end
        m_ret = m_ret + 1;
        push(PH_O, 1'b0, mc[13], 1'b1, inst, mc, hit);
    endtask

    task automatic add_tail(input int n);
        for (int i = 0; i < n; i++) push(PH_O, 1'b0, 1'b0, 1'b0, $urandom, 14'($urandom), 1'($urandom));
    endtask

    task automatic idle_inputs();
        ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
        ifu_resp_inst = '0; micro_cmd = '0; micro_hit = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_halted = 1'b0; m_we = 1'b0; m_code = '0; m_sz = '0;
        m_ret = '0; m_inst = '0; m_micro = '0; mark = -1;
        tr.delete();
    endtask

    task automatic run_trace(input int stop);
        obs.delete();
        for (int i = 0; i < tr.size() && i < stop; i++) begin
            @(negedge clk);
            obs.push_back({ifu_req_valid, lsu_req_valid, lsu_req_valid ? lsu_req_we : 1'b0,
                           lsu_req_valid ? lsu_req_size : 2'b00, rf_wen, pc_wen, halted,
                           halted ? halt_code : 2'b00, instret, inst_q, micro_q});
            ifu_req_ready  = tr[i].f_rdy;
            ifu_resp_valid = tr[i].f_rsp;
            lsu_req_ready  = tr[i].l_rdy;
            lsu_resp_valid = tr[i].l_rsp;
            ifu_resp_inst  = tr[i].rinst;
            micro_cmd      = tr[i].mc;
            micro_hit      = tr[i].hit;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1; lsu_req_ready = 1'b1; lsu_resp_valid = 1'b1;
        ifu_resp_inst = $urandom; micro_cmd = '1; micro_hit = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifu_req_valid, lsu_req_valid, lsu_req_we, lsu_req_size, rf_wen, pc_wen, halted,
             halt_code, instret, inst_q, micro_q} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ifu_v=%b lsu_v=%b halted=%b instret=%0d inst_q=%h required all 0",
                     ifu_req_valid, lsu_req_valid, halted, instret, inst_q);
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ifu_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_to_fetch: ifu_req_valid=%b required 1", ifu_req_valid);
        end
    endtask

    task automatic test_addi();
        int first_pc;
        do_reset();
        add_inst(32'h0050_0093, 14'h2001, 1'b1, 0, 0, 0, 0);
        add_inst(32'h0010_8113, 14'h2011, 1'b1, 0, 0, 0, 0);
        run_trace(tr.size());
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== tr[i].exp) begin
                failures++;
                $display("FAIL addi cyc%0d got=%h required=%h", i, obs[i], tr[i].exp);
            end
        end
        first_pc = -1;
        foreach (obs[i]) if (first_pc < 0 && obs[i][B_PC]) first_pc = i;
        checks++;
        if (first_pc !== 4) begin
            failures++;
            $display("FAIL addi_latency: first pc_wen at cycle %0d required 4", first_pc);
        end
    endtask

    task automatic test_store();
        int nv;
        do_reset();
        add_inst(32'h00a1_2223, 14'h0602, 1'b1, 0, 0, 3, $urandom_range(0, 3));
        run_trace(tr.size());
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== tr[i].exp) begin
                failures++;
                $display("FAIL store cyc%0d got=%h required=%h", i, obs[i], tr[i].exp);
            end
        end
        nv = 0;
        foreach (obs[i]) if (obs[i][B_LSU]) nv++;
        checks++;
        if (nv !== 4) begin
            failures++;
            $display("FAIL store_valid_hold: lsu_req_valid cycles=%0d required 4", nv);
        end
    endtask

    task automatic test_load_ebreak();
        do_reset();
        add_inst(32'h0041_4083, 14'h20A3, 1'b1, $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));
        add_inst(EBREAK, 14'($urandom), 1'b0, 1, 1, 0, 0);
        add_tail(4);
        run_trace(tr.size());
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== tr[i].exp) begin
                failures++;
                $display("FAIL load_ebreak cyc%0d got=%h required=%h", i, obs[i], tr[i].exp);
            end
        end
        checks++;
        if (halted !== 1'b1 || halt_code !== 2'd0 || instret !== 32'd1) begin
            failures++;
            $display("FAIL ebreak_final: halted=%b code=%0d instret=%0d required 1/0/1",
                     halted, halt_code, instret);
        end
    endtask

    task automatic test_illegal();
        int npc;
        do_reset();
        add_inst(32'hFFFF_FFFF, 14'($urandom), 1'b0, 0, 2, 0, 0);
        add_tail(6);
        run_trace(tr.size());
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== tr[i].exp) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%h required=%h", i, obs[i], tr[i].exp);
            end
        end
        npc = 0;
        foreach (obs[i]) if (obs[i][B_PC]) npc++;
        checks++;
        if (npc !== 0 || halt_code !== 2'd1) begin
            failures++;
            $display("FAIL illegal_final: pc_wen count=%0d code=%0d required 0/1", npc, halt_code);
        end
    endtask

    task automatic test_timeout();
        int t_iw, t_h;
        do_reset();
        add_inst(32'h0000_0013, 14'h2000, 1'b1, 0, 1000, 0, 0);
        add_tail(3);
        run_trace(tr.size());
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== tr[i].exp) begin
                failures++;
                $display("FAIL timeout_iwait cyc%0d got=%h required=%h", i, obs[i], tr[i].exp);
            end
        end
        t_iw = -1; t_h = -1;
        foreach (obs[i]) begin
            if (t_iw < 0 && !obs[i][B_IFU]) t_iw = i;
            if (t_h < 0 && obs[i][B_HALT]) t_h = i;
        end
        checks++;
        if (t_h - t_iw !== TO || halt_code !== 2'd2) begin
            failures++;
            $display("FAIL timeout_latency: halt %0d cycles after IWAIT code=%0d required %0d/2",
                     t_h - t_iw, halt_code, TO);
        end
        // last-allowed-cycle responses win, then a stalled store request times out
        do_reset();
        add_inst(32'h0011_2023, 14'h0400, 1'b1, TO - 1, TO - 1, TO - 1, TO - 1);
        add_inst(32'h0021_2023, 14'h0600, 1'b1, 0, 0, TO, 0);
        add_tail(3);
        run_trace(tr.size());
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== tr[i].exp) begin
                failures++;
                $display("FAIL timeout_boundary cyc%0d got=%h required=%h", i, obs[i], tr[i].exp);
            end
        end
        checks++;
        if (instret !== 32'd1 || halt_code !== 2'd2 || halted !== 1'b1) begin
            failures++;
            $display("FAIL boundary_final: instret=%0d code=%0d halted=%b required 1/2/1",
                     instret, halt_code, halted);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_inst(32'h0050_0093, 14'h2001, 1'b1, 0, 0, 0, 0);
        add_inst(32'h0000_2103, 14'h2180, 1'b1, 0, 0, 0, 5);
        run_trace(mark + 2);
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== tr[i].exp) begin
                failures++;
                $display("FAIL reset_mid_pre cyc%0d got=%h required=%h", i, obs[i], tr[i].exp);
            end
        end
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifu_req_valid, lsu_req_valid, lsu_req_we, lsu_req_size, rf_wen, pc_wen, halted,
             halt_code, instret, inst_q, micro_q} !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear: ifu_v=%b lsu_v=%b instret=%0d inst_q=%h micro_q=%h required all 0",
                     ifu_req_valid, lsu_req_valid, instret, inst_q, micro_q);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ifu_req_valid !== 1'b1 || instret !== 32'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_restart: ifu_v=%b instret=%0d halted=%b required 1/0/0",
                     ifu_req_valid, instret, halted);
        end
    endtask

    task automatic gen_inst();
        logic [31:0] inst;
        logic [13:0] mc;
        logic        hit;
        int          d[4];
        int          r;
        inst = $urandom;
        if (inst == EBREAK) inst = inst ^ 32'h1;
        mc  = 14'($urandom);
        hit = 1'b1;
        r = $urandom_range(0, 11);
        if (r == 0) inst = EBREAK;
        else if (r == 1) hit = 1'b0;
        case ($urandom_range(0, 3))
            0: mc[10:7] = 4'b0000;
            1: begin mc[10:9] = 2'b00; mc[8:7] = 2'($urandom_range(1, 3)); end
            2: begin mc[10:9] = 2'($urandom_range(1, 3)); mc[8:7] = 2'b00; end
            default: begin mc[10:9] = 2'($urandom_range(1, 3)); mc[8:7] = 2'($urandom_range(1, 3)); end
        endcase
        for (int j = 0; j < 4; j++) begin
            r = $urandom_range(0, 19);
            d[j] = (r < 1) ? TO + 2 : (r < 3) ? TO - 1 : $urandom_range(0, 3);
        end
        add_inst(inst, mc, hit, d[0], d[1], d[2], d[3]);
    endtask

    task automatic test_random();
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int k = 0; k < 12; k++) gen_inst();
            add_tail(3);
            run_trace(tr.size());
            foreach (obs[i]) begin
                checks++;
                if (obs[i] !== tr[i].exp) begin
                    failures++;
                    $display("FAIL random p%0d cyc%0d got=%h required=%h", p, i, obs[i], tr[i].exp);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_addi();
        test_store();
        test_load_ebreak();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
